// File: rtl/fp_cmp_pkg.sv
// rtl/fp_cmp_pkg.sv - exception encodings and operand field helpers for the shared FP compare
package fp_cmp_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam int EXP_W = 11;

    // Exception class and sign of the difference A - B; all the decision stage needs.
    typedef struct packed {
        logic [1:0] ex;
        logic       s;
    } diff_t;

    function automatic int exc_hi(input int width);
        return width;
    endfunction

    function automatic int exc_lo(input int width);
        return width - 1;
    endfunction

    function automatic int sign_bit(input int width);
        return width - 2;
    endfunction

endpackage

// File: rtl/fp_le_core.sv
// rtl/fp_le_core.sv - pipelined FP subtract (class/sign of A-B) plus registered A<=B decision
module fp_le_core
    import fp_cmp_pkg::*;
#(
    parameter int WIDTH   = 34,
    parameter int SUB_LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic           le,
    output logic           unord
);

    localparam int EXH = exc_hi(WIDTH);
    localparam int EXL = exc_lo(WIDTH);
    localparam int SGN = sign_bit(WIDTH);

    logic [1:0]   ea;
    logic [1:0]   eb;
    logic         sa;
    logic         sb;
    logic [SGN:0] ma;
    logic [SGN:0] mb;
    logic         a_top;
    logic         b_top;
    diff_t        diff;
    diff_t        pipe [SUB_LAT];

    assign ea    = a[EXH:EXL];
    assign eb    = b[EXH:EXL];
    assign sa    = a[SGN];
    assign sb    = b[SGN];
    // Magnitude with hidden one; zeros collapse to 0 so +0 and -0 compare equal.
    assign ma    = (ea == EXC_NORMAL) ? {1'b1, a[SGN-1:0]} : '0;
    assign mb    = (eb == EXC_NORMAL) ? {1'b1, b[SGN-1:0]} : '0;
    assign a_top = &a[SGN-1 -: EXP_W];
    assign b_top = &b[SGN-1 -: EXP_W];

    always_comb begin
        diff    = '0;
        diff.ex = EXC_NORMAL;
        if (ea == EXC_NAN || eb == EXC_NAN) begin
            diff.ex = EXC_NAN;
        end else if (ea == EXC_INF && eb == EXC_INF) begin
            if (sa == sb) begin
                diff.ex = EXC_NAN;
            end else begin
                diff.ex = EXC_INF;
                diff.s  = sa;
            end
        end else if (ea == EXC_INF) begin
            diff.ex = EXC_INF;
            diff.s  = sa;
        end else if (eb == EXC_INF) begin
            diff.ex = EXC_INF;
            diff.s  = ~sb;
        end else if (ma == '0 && mb == '0) begin
            diff.ex = EXC_ZERO;
        end else if (sa != sb) begin
            // Effective addition: result takes A's sign and can overflow at the top binade.
            diff.s = sa;
            if (ea == EXC_NORMAL && eb == EXC_NORMAL && a_top && b_top) begin
                diff.ex = EXC_INF;
            end
        end else if (ma == mb) begin
            diff.ex = EXC_ZERO;
        end else begin
            diff.s = (ma > mb) ? sa : ~sa;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SUB_LAT; i++) begin
                pipe[i] <= '0;
            end
            le    <= 1'b0;
            unord <= 1'b0;
        end else begin
            pipe[0] <= diff;
            for (int i = 1; i < SUB_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            case (pipe[SUB_LAT-1].ex)
                EXC_ZERO: begin
                    le    <= 1'b1;
                    unord <= 1'b0;
                end
                EXC_NAN: begin
                    le    <= 1'b0;
                    unord <= 1'b1;
                end
                default: begin
                    le    <= pipe[SUB_LAT-1].s;
                    unord <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// rtl/fp_cmp_arbiter.sv - round-robin sharing of one pipelined FP A<=B comparator with ID tagging
module fp_cmp_arbiter
    import fp_cmp_pkg::*;
#(
    parameter int WIDTH   = 34,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int SUB_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0] req_a,
    input  logic [NREQ*(WIDTH+1)-1:0] req_b,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic                      rsp_le,
    output logic                      rsp_unord,
    output logic                      busy
);

    localparam int             OPW    = WIDTH + 1;
    localparam int             DEPTH  = SUB_LAT + 1;
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    logic [IDW:0]     cand;
    logic [WIDTH:0]   a_sel;
    logic [WIDTH:0]   b_sel;
    logic [DEPTH-1:0] tag_valid;
    logic [IDW-1:0]   tag_id [DEPTH];
    logic             core_le;
    logic             core_unord;
    logic             le_hold;
    logic             unord_hold;

    // First asserted request scanning upward from the pointer, wrapping at NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + k[IDW:0];
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!gnt_any && !rst && req_valid[cand[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && gnt_id == i[IDW-1:0]) begin
                req_ready[i] = 1'b1;
                a_sel        = req_a[i*OPW +: OPW];
                b_sel        = req_b[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= ({1'b0, gnt_id} == NREQ_W - 1'b1) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_id[i] <= '0;
            end
            le_hold    <= 1'b0;
            unord_hold <= 1'b0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], gnt_any};
            tag_id[0] <= gnt_id;
            for (int i = 1; i < DEPTH; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
            le_hold    <= rsp_le;
            unord_hold <= rsp_unord;
        end
    end

    fp_le_core #(
        .WIDTH  (WIDTH),
        .SUB_LAT(SUB_LAT)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .a    (a_sel),
        .b    (b_sel),
        .le   (core_le),
        .unord(core_unord)
    );

    // Core decision register runs every cycle; outputs freeze on the last real result.
    assign rsp_valid = tag_valid[DEPTH-1];
    assign rsp_id    = tag_id[DEPTH-1];
    assign rsp_le    = rsp_valid ? core_le : le_hold;
    assign rsp_unord = rsp_valid ? core_unord : unord_hold;
    assign busy      = |tag_valid;

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// tb/tb_fp_cmp_arbiter.sv - scoreboard bench for the shared FP compare arbiter
module tb_fp_cmp_arbiter;

    localparam int WIDTH   = 34;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int SUB_LAT = 3;
    localparam int OPW     = WIDTH + 1;

    localparam logic [WIDTH:0] ONE   = {2'b01, 1'b0, 11'd1023, 21'd0};
    localparam logic [WIDTH:0] TWO   = {2'b01, 1'b0, 11'd1024, 21'd0};
    localparam logic [WIDTH:0] THREE = {2'b01, 1'b0, 11'd1024, 21'h100000};
    localparam logic [WIDTH:0] PZERO = {2'b00, 1'b0, 11'd0, 21'd0};
    localparam logic [WIDTH:0] NZERO = {2'b00, 1'b1, 11'd0, 21'd0};
    localparam logic [WIDTH:0] PMAX  = {2'b01, 1'b0, 11'h7FF, 21'h1FFFFF};
    localparam logic [WIDTH:0] NMAX  = {2'b01, 1'b1, 11'h7FF, 21'h1FFFFF};
    localparam logic [WIDTH:0] QNAN  = {2'b11, 1'b0, 11'h7FF, 21'd1};

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_a = '0;
    logic [NREQ*OPW-1:0]   req_b = '0;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_le;
    logic                  rsp_unord;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;
    int ptr = 0;

    typedef struct {
        int id;
        bit le;
        bit unord;
    } exp_t;

    exp_t sb_q[$];

    fp_cmp_arbiter #(
        .WIDTH  (WIDTH),
        .NREQ   (NREQ),
        .IDW    (IDW),
        .SUB_LAT(SUB_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_le   (rsp_le),
        .rsp_unord(rsp_unord),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Signed ordering key: infinities sit beyond every finite magnitude.
    function automatic longint order_key(input logic [WIDTH:0] x);
        longint m;
        case (x[WIDTH:WIDTH-1])
            2'b00:   m = 0;
            2'b01:   m = longint'({1'b1, x[WIDTH-3:0]});
            default: m = longint'(1) << 40;
        endcase
        return x[WIDTH-2] ? -m : m;
    endfunction

    function automatic exp_t ref_cmp(input int id, input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        exp_t e;
        logic [1:0] xa = a[WIDTH:WIDTH-1];
        logic [1:0] xb = b[WIDTH:WIDTH-1];
        e.id    = id;
        e.unord = (xa == 2'b11) || (xb == 2'b11) ||
                  (xa == 2'b10 && xb == 2'b10 && a[WIDTH-2] == b[WIDTH-2]);
        e.le    = !e.unord && (order_key(a) <= order_key(b));
        return e;
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH:0] rand_op();
        int r = $urandom_range(0, 9);
        logic [1:0]  e;
        logic [10:0] ex;
        logic [20:0] f;
        e  = (r < 6) ? 2'b01 : (r == 6) ? 2'b00 : (r == 7) ? 2'b10 : 2'b11;
        ex = 11'(1022 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) ex = 11'h7FF;
        f  = 21'($urandom_range(0, 3)) << 19;
        return {e, 1'($urandom_range(0, 1)), ex, f};
    endfunction

    task automatic set_ops(input int i, input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        req_a[i*OPW +: OPW] = a;
        req_b[i*OPW +: OPW] = b;
    endtask

    // Scoreboard: push on every observed transfer, pop on every response.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    expect_eq("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    expect_eq("rsp_id", 64'(rsp_id), 64'(e.id));
                    expect_eq("rsp_le", 64'(rsp_le), 64'(e.le));
                    expect_eq("rsp_unord", 64'(rsp_unord), 64'(e.unord));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back(ref_cmp(i, req_a[i*OPW +: OPW], req_b[i*OPW +: OPW]));
                end
            end
        end
    end

    task automatic drain();
        repeat (SUB_LAT + 3) @(posedge clk);
        #1;
        expect_eq("drain_empty", 64'(sb_q.size()), 0);
        expect_eq("drain_busy", 64'(busy), 0);
    endtask

    task automatic issue_one(input int id, input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        set_ops(id, a, b);
        @(negedge clk);
        expect_eq("single_grant", 64'(req_ready), 64'd1 << id);
        expect_eq("busy_in_xfer", 64'(busy), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        ptr = (id + 1) % NREQ;
        for (int c = 1; c <= SUB_LAT + 2; c++) begin
            @(negedge clk);
            expect_eq("busy_window", 64'(busy), 64'(c <= SUB_LAT + 1));
            expect_eq("rsp_latency", 64'(rsp_valid), 64'(c == SUB_LAT + 1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int g;
        req_valid = 4'hF;
        @(negedge clk);
        expect_eq("reset_ready", 64'(req_ready), 0);
        expect_eq("reset_rsp_valid", 64'(rsp_valid), 0);
        expect_eq("reset_rsp_id", 64'(rsp_id), 0);
        expect_eq("reset_rsp_le", 64'(rsp_le), 0);
        expect_eq("reset_rsp_unord", 64'(rsp_unord), 0);
        expect_eq("reset_busy", 64'(busy), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue_one(2, ONE, TWO);
        issue_one(0, THREE, ONE);
        issue_one(0, PZERO, NZERO);
        issue_one(0, NMAX, PMAX);
        issue_one(0, QNAN, ONE);

        // All requesters asserting: one grant per cycle in rotation, operands refreshed on grant.
        for (int i = 0; i < NREQ; i++) set_ops(i, rand_op(), rand_op());
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            g = exp_grant(req_valid, ptr);
            expect_eq("rr_grant", 64'(req_ready), 64'd1 << g);
            expect_eq("rr_stream", 64'(rsp_valid), 64'(k >= SUB_LAT + 1));
            @(posedge clk);
            #1;
            ptr = (g + 1) % NREQ;
            set_ops(g, rand_op(), rand_op());
        end
        req_valid = '0;
        drain();

        // Pointer parked at 3 with only requesters 1 and 3 competing.
        issue_one(2, rand_op(), rand_op());
        set_ops(1, rand_op(), rand_op());
        set_ops(3, rand_op(), rand_op());
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            g = exp_grant(req_valid, ptr);
            expect_eq("skip_grant", 64'(req_ready), 64'd1 << g);
            @(posedge clk);
            #1;
            ptr = (g + 1) % NREQ;
            set_ops(g, rand_op(), rand_op());
        end
        req_valid = '0;
        drain();

        // Requester 1 waits behind 0 and must return its own result.
        set_ops(0, THREE, ONE);
        set_ops(1, ONE, THREE);
        req_valid = 4'b0011;
        @(negedge clk);
        expect_eq("hold_grant0", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        expect_eq("hold_grant1", 64'(req_ready), 64'h2);
        @(posedge clk);
        #1;
        req_valid = '0;
        ptr = 2;
        drain();

        // Three compares in flight, then reset discards them.
        for (int i = 0; i < NREQ; i++) set_ops(i, rand_op(), rand_op());
        req_valid = 4'hF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        req_valid = 4'b1100;
        repeat (2) begin
            @(negedge clk);
            expect_eq("rst_ready", 64'(req_ready), 0);
            expect_eq("rst_rsp_valid", 64'(rsp_valid), 0);
            expect_eq("rst_busy", 64'(busy), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ptr = 0;
        @(negedge clk);
        expect_eq("post_rst_grant", 64'(req_ready), 64'h4);
        @(posedge clk);
        #1;
        @(negedge clk);
        expect_eq("post_rst_next", 64'(req_ready), 64'h8);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
